sha512_ctrl: RTL

Sequencer between the AXI4-Lite register slave of the sha512 IP and the SHA-512 core.
- Buffers a 1024-bit message block written as 32 x 32-bit words.
- Issues init/next commands to the core and tracks completion.
- Latches the 512-bit digest into a readable 16-word buffer.
- Maintains status, a block counter, a sticky error flag and a done interrupt pulse.

---
 rtl/sha512_ctrl_pkg.sv | 20 ++
 rtl/sha512_ctrl_wbuf.sv | 32 +++
 rtl/sha512_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sha512_ctrl_pkg.sv
// Shared types and constants for the SHA-512 controller slice.
package sha512_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_CAPTURE
  } ctrl_state_t;

  localparam logic [1:0] MODE_224 = 2'd0;
  localparam logic [1:0] MODE_256 = 2'd1;
  localparam logic [1:0] MODE_384 = 2'd2;
  localparam logic [1:0] MODE_512 = 2'd3;

  localparam int BLOCK_WORDS  = 32;
  localparam int DIGEST_WORDS = 16;

endpackage

// File: rtl/sha512_ctrl_wbuf.sv
// 32-word message block buffer; word 0 lands in the most significant bits
// of the flattened block handed to the core.
module sha512_ctrl_wbuf
  import sha512_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [4:0]                    wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic [BLOCK_WORDS*DATA_W-1:0] block
);

  logic [DATA_W-1:0] mem [BLOCK_WORDS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BLOCK_WORDS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    block = '0;
    for (int i = 0; i < BLOCK_WORDS; i++)
      block[(BLOCK_WORDS-1-i)*DATA_W +: DATA_W] = mem[i];
  end

endmodule

// File: rtl/sha512_ctrl.sv
// Sequencer between the register slave and the SHA-512 core: buffers a block,
// issues init/next, waits for the core and latches the digest for readback.
module sha512_ctrl
  import sha512_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                           S_AXI_ACLK,
  input  logic                           S_AXI_ARESETN,
  input  logic                           wr_en,
  input  logic [4:0]                     wr_addr,
  input  logic [DATA_W-1:0]              wr_data,
  input  logic                           cmd_init,
  input  logic                           cmd_next,
  input  logic [1:0]                     mode_in,
  input  logic                           err_clr,
  input  logic [3:0]                     rd_addr,
  output logic [DATA_W-1:0]              rd_data,
  output logic                           busy,
  output logic                           digest_valid,
  output logic                           err,
  output logic                           irq,
  output logic [CNT_W-1:0]               block_count,
  output logic                           core_init,
  output logic                           core_next,
  output logic [1:0]                     core_mode,
  output logic [BLOCK_WORDS*DATA_W-1:0]  core_block,
  input  logic                           core_ready,
  input  logic [DIGEST_WORDS*DATA_W-1:0] core_digest,
  input  logic                           core_digest_valid
);

  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  ctrl_state_t       state, state_nxt;
  logic              is_init;
  logic [TMR_W-1:0]  ack_tmr;
  logic [DATA_W-1:0] digest_buf [DIGEST_WORDS];
  logic              cmd_any, accept, ack_timeout, err_set, wbuf_we;

  sha512_ctrl_wbuf #(.DATA_W(DATA_W)) u_wbuf (
    .clk     (S_AXI_ACLK),
    .rst_n   (S_AXI_ARESETN),
    .wr_en   (wbuf_we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .block   (core_block)
  );

  assign cmd_any   = cmd_init | cmd_next;
  assign busy      = (state != ST_IDLE);
  assign core_init = (state == ST_ISSUE) &&  is_init;
  assign core_next = (state == ST_ISSUE) && !is_init;
  assign irq       = (state == ST_CAPTURE);
  assign wbuf_we   = wr_en && !busy;
  assign err_set   = (busy && (wr_en || cmd_any)) || ack_timeout;

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    ack_timeout = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_any) begin
          accept    = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE:     state_nxt = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (!core_ready) begin
          state_nxt = ST_WAIT_DONE;
        end else if (ack_tmr == TMR_LAST) begin
          ack_timeout = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      ST_WAIT_DONE: if (core_ready && core_digest_valid) state_nxt = ST_CAPTURE;
      ST_CAPTURE:   state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // The ack timer only matters in WAIT_ACK, which is always entered from ISSUE
  // where the timer is zeroed.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state        <= ST_IDLE;
      is_init      <= 1'b0;
      ack_tmr      <= '0;
      core_mode    <= '0;
      digest_valid <= 1'b0;
      block_count  <= '0;
      err          <= 1'b0;
    end else begin
      state   <= state_nxt;
      ack_tmr <= (state == ST_WAIT_ACK) ? ack_tmr + 1'b1 : '0;
      if (accept) begin
        is_init      <= cmd_init;
        core_mode    <= mode_in;
        digest_valid <= 1'b0;
        if (cmd_init) block_count <= '0;
      end
      if (state == ST_CAPTURE) begin
        digest_valid <= 1'b1;
        block_count  <= block_count + 1'b1;
      end
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < DIGEST_WORDS; i++) digest_buf[i] <= '0;
      rd_data <= '0;
    end else begin
      if (state == ST_CAPTURE) begin
        for (int i = 0; i < DIGEST_WORDS; i++)
          digest_buf[i] <= core_digest[(DIGEST_WORDS-1-i)*DATA_W +: DATA_W];
      end
      rd_data <= digest_buf[rd_addr];
    end
  end

endmodule
